// File: rtl/lib_pkg.sv
// ---------------------------------------------------------------------------
// lib_pkg -- shared helpers for the lib_* datapath blocks.
//   lane_slice : extract lane idx (w bits wide) from a packed lane vector.
//   sat_inc    : increment a w-bit value, sticking at 2^w-1 instead of wrapping.
// Both take the width as an argument so one definition serves every instance;
// callers cast the 32-bit result back to their own width.
// ---------------------------------------------------------------------------
package lib_pkg;

    localparam int LIB_MAXW = 32;   // widest lane / counter supported
    localparam int LIB_MAXV = 256;  // widest packed lane vector supported

    function automatic logic [LIB_MAXW-1:0] lane_slice(
        input logic [LIB_MAXV-1:0] vec,
        input int unsigned         idx,
        input int unsigned         w
    );
        logic [LIB_MAXW-1:0] r;
        r = LIB_MAXW'(vec >> (idx * w));
        for (int unsigned k = 0; k < LIB_MAXW; k++) begin
            if (k >= w) r[k] = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [LIB_MAXW-1:0] sat_inc(
        input logic [LIB_MAXW-1:0] v,
        input int unsigned         w
    );
        logic [LIB_MAXW-1:0] top;
        top = '0;
        for (int unsigned k = 0; k < LIB_MAXW; k++) begin
            if (k < w) top[k] = 1'b1;
        end
        return (v >= top) ? top : v + 1'b1;
    endfunction

endpackage

// File: rtl/lib_sop_lane.sv
// ---------------------------------------------------------------------------
// lib_sop_lane -- one registered multiplier lane; the product is truncated to
// W bits (only the low W bits ever matter to the modulo-2^W sum downstream).
//   clk, rst : clock, async active-high reset
//   i_en     : load a new product this cycle
//   i_a, i_b : W-bit operands
//   o_prod   : registered W-bit product
// ---------------------------------------------------------------------------
module lib_sop_lane #(
    parameter int W = 18
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_prod
);

    logic [W-1:0] r_prod;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       r_prod <= '0;
        else if (i_en) r_prod <= W'(i_a * i_b);
    end

    assign o_prod = r_prod;

endmodule

// File: rtl/lib_sop_pipe.sv
// ---------------------------------------------------------------------------
// lib_sop_pipe -- pipelined sum-of-products accumulator.
// Each input beat carries P operand pairs; the block sums a_i*b_i over the beat
// and accumulates beat sums until a beat flagged last, then emits the group sum
// (mod 2^W) and the beat count (saturating at 2^CW-1).
//   S1  : per-lane registered products (lib_sop_lane x P), last, valid
//   S2  : registered beat_sum of the S1 products, last, valid
//   out : result register (out_data/out_beats), valid/ready handshake
// A non-last beat leaving S2 only touches acc/cnt, so it never waits on the
// output register; only a last beat stalls behind an undrained result.
//   clk, rst                      : clock, async active-high reset
//   in_valid/in_ready             : input handshake
//   in_a, in_b                    : P lanes of W bits, lane i at [i*W +: W]
//   in_last                       : beat closes the group
//   out_valid/out_ready           : output handshake
//   out_data, out_beats           : group sum, beat count
// ---------------------------------------------------------------------------
module lib_sop_pipe
    import lib_pkg::*;
#(
    parameter int W  = 18,
    parameter int P  = 3,
    parameter int CW = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [P*W-1:0] in_a,
    input  logic [P*W-1:0] in_b,
    input  logic           in_last,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output logic [CW-1:0]  out_beats
);

    logic              r_s1_vld, r_s1_last;
    logic              r_s2_vld, r_s2_last;
    logic [W-1:0]      r_s2_sum;
    logic [W-1:0]      r_acc;
    logic [CW-1:0]     r_cnt;
    logic              r_out_vld;
    logic [W-1:0]      r_out_data;
    logic [CW-1:0]     r_out_beats;

    logic              w_s1_adv, w_s2_adv, w_s2_fire, w_take;
    logic [P-1:0][W-1:0] w_prod;
    logic [P:0][W-1:0]   w_part;
    logic [W-1:0]      w_acc_sum;
    logic [CW-1:0]     w_cnt_inc;

    // Handshake: in_ready is derived from registered state and out_ready only.
    assign w_s2_adv  = !r_s2_vld || !r_s2_last || !r_out_vld || out_ready;
    assign w_s1_adv  = !r_s1_vld || w_s2_adv;
    assign in_ready  = w_s1_adv && !rst;
    assign w_take    = in_valid && in_ready;
    assign w_s2_fire = r_s2_vld && w_s2_adv;

    // S1 lanes and the S2 reduction chain (combinational, feeds r_s2_sum).
    assign w_part[0] = '0;
    for (genvar gi = 0; gi < P; gi++) begin : g_lane
        logic [W-1:0] w_a, w_b;
        assign w_a = W'(lane_slice(LIB_MAXV'(in_a), gi, W));
        assign w_b = W'(lane_slice(LIB_MAXV'(in_b), gi, W));

        lib_sop_lane #(.W(W)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .i_en   (w_take),
            .i_a    (w_a),
            .i_b    (w_b),
            .o_prod (w_prod[gi])
        );

        assign w_part[gi+1] = w_part[gi] + w_prod[gi];
    end

    assign w_acc_sum = r_acc + r_s2_sum;
    assign w_cnt_inc = CW'(sat_inc(LIB_MAXW'(r_cnt), CW));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_last <= 1'b0;
            r_s2_vld  <= 1'b0;
            r_s2_last <= 1'b0;
            r_s2_sum  <= '0;
        end else begin
            if (w_s1_adv) begin
                r_s1_vld  <= w_take;
                r_s1_last <= w_take && in_last;
            end
            if (w_s2_adv) begin
                r_s2_vld  <= r_s1_vld;
                r_s2_last <= r_s1_last;
                r_s2_sum  <= w_part[P];
            end
        end
    end

    // Group accumulation and result register. A drain and a new load in the
    // same cycle is legal: the load wins and out_valid stays high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_vld   <= 1'b0;
            r_out_data  <= '0;
            r_out_beats <= '0;
        end else begin
            if (r_out_vld && out_ready) r_out_vld <= 1'b0;
            if (w_s2_fire) begin
                if (r_s2_last) begin
                    r_out_vld   <= 1'b1;
                    r_out_data  <= w_acc_sum;
                    r_out_beats <= w_cnt_inc;
                    r_acc       <= '0;
                    r_cnt       <= '0;
                end else begin
                    r_acc <= w_acc_sum;
                    r_cnt <= w_cnt_inc;
                end
            end
        end
    end

    assign out_valid = r_out_vld;
    assign out_data  = r_out_data;
    assign out_beats = r_out_beats;

endmodule
